// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. Owns the PC, keeps at most one fetch
// outstanding on the instruction bus, and holds one fetched {pc, inst} for the
// IF/ID register. EX redirects may land at any point of a fetch; a fetch that
// was already granted before the redirect is marked stale (kill) and its
// response is dropped when it returns.
`timescale 1ns/1ps

module if_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  stall,
    output logic                  ibus_req,
    output logic [ADDR_WIDTH-1:0] ibus_addr,
    input  logic                  ibus_gnt,
    input  logic                  ibus_rvalid,
    input  logic [INST_WIDTH-1:0] ibus_rdata,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_VALID} state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   redir_addr;
    logic                    redir_pend;
    logic                    kill;
    logic [ADDR_WIDTH-1:0]   jump_tgt;

    // Redirect targets are always word aligned, whatever EX supplies.
    assign jump_tgt  = jump_addr & ALIGN_MASK;
    assign ibus_addr = pc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: a returning response goes back to REQ when it is stale
    // (killed, or a redirect arrives in the same cycle), otherwise to VALID.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (ibus_gnt) state_nxt = S_WAIT;
            S_WAIT:  if (ibus_rvalid) state_nxt = (kill || jump_en) ? S_REQ : S_VALID;
            S_VALID: if (jump_en || !stall) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state: only REQ drives a bus request.
    always_comb begin
        ibus_req = 1'b0;
        if (state == S_REQ) ibus_req = 1'b1;
    end

    // PC, redirect bookkeeping and the held instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= PC_RST;
            redir_addr <= '0;
            redir_pend <= 1'b0;
            kill       <= 1'b0;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_inst    <= NOP_INST;
        end else begin
            case (state)
                S_REQ: begin
                    if (ibus_gnt) begin
                        // The granted address is now obsolete if a redirect
                        // is pending or arriving; a live jump beats a pending one.
                        redir_pend <= 1'b0;
                        if (jump_en) begin
                            kill <= 1'b1;
                            pc   <= jump_tgt;
                        end else if (redir_pend) begin
                            kill <= 1'b1;
                            pc   <= redir_addr;
                        end
                    end else if (jump_en) begin
                        // Address must stay stable until grant: park the jump.
                        redir_pend <= 1'b1;
                        redir_addr <= jump_tgt;
                    end
                end
                S_WAIT: begin
                    if (ibus_rvalid) begin
                        if (kill || jump_en) begin
                            kill <= 1'b0;
                            if (jump_en) pc <= jump_tgt;
                        end else begin
                            if_pc    <= pc;
                            if_inst  <= ibus_rdata;
                            if_valid <= 1'b1;
                            pc       <= pc + ADDR_WIDTH'(4);
                        end
                    end else if (jump_en) begin
                        kill <= 1'b1;
                        pc   <= jump_tgt;
                    end
                end
                S_VALID: begin
                    if (jump_en) begin
                        if_valid <= 1'b0;
                        if_inst  <= NOP_INST;
                        pc       <= jump_tgt;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a bus-slave model with randomised grant and
// response latency, a stimulus process issuing stalls, redirects and resets,
// and an independent monitor that checks each presented instruction against
// the expected program-order stream held in a scoreboard queue.
`timescale 1ns/1ps

module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        stall;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int          nchk = 0;
    int          nfail = 0;
    int          rises = 0;
    int          gnt_pct = 100;
    int          max_lat = 1;
    bit          spur = 0;
    bit          chk_period = 0;
    int          quiet = 0;
    logic [31:0] exp_q[$];

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .stall       (stall),
        .ibus_req    (ibus_req),
        .ibus_addr   (ibus_addr),
        .ibus_gnt    (ibus_gnt),
        .ibus_rvalid (ibus_rvalid),
        .ibus_rdata  (ibus_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents seen by the slave and the reference stream.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Program order from a fetch start point: sequential words, wrapping at 2^32.
    task automatic set_target(input logic [31:0] t);
        exp_q.delete();
        for (int k = 0; k < 256; k++) exp_q.push_back(t + 32'(4 * k));
    endtask

    task automatic do_jump(input logic [31:0] a);
        jump_en   = 1;
        jump_addr = a;
        set_target(a & ~32'h3);
        @(negedge clk);
        jump_en = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst     = 1;
        jump_en = 0;
        set_target(32'h0);
        @(negedge clk);
        @(negedge clk);
        rst   = 0;
        quiet = 3;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!if_valid && n < 80) begin @(negedge clk); n++; end
        check(if_valid == 1'b1, nm, 32'(if_valid), 32'h1);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!ibus_req && n < 80) begin @(negedge clk); n++; end
        check(ibus_req == 1'b1, nm, 32'(ibus_req), 32'h1);
    endtask

    // Bus slave: grants randomly, answers 1..max_lat cycles after grant,
    // throws in ignored grants while idle and ignored rvalids when nothing is outstanding.
    initial begin
        logic        acc_req, pend;
        logic [31:0] acc_addr, pend_addr;
        int          pend_cnt;
        acc_req = 0; pend = 0; acc_addr = 0; pend_addr = 0; pend_cnt = 0;
        ibus_gnt = 0; ibus_rvalid = 0; ibus_rdata = 0;
        forever begin
            @(negedge clk);
            ibus_rvalid = 0;
            ibus_rdata  = $urandom();
            if (rst) begin
                acc_req  = 0;
                pend     = 0;
                ibus_gnt = 0;
            end else begin
                if (ibus_gnt && acc_req) begin
                    pend      = 1;
                    pend_addr = acc_addr;
                    pend_cnt  = $urandom_range(1, max_lat);
                end
                if (pend) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        ibus_rvalid = 1;
                        ibus_rdata  = mem(pend_addr);
                        pend        = 0;
                    end
                end else if (spur && $urandom_range(0, 99) < 5) begin
                    ibus_rvalid = 1;
                end
                acc_req  = ibus_req;
                acc_addr = ibus_addr;
                ibus_gnt = ibus_req ? ($urandom_range(0, 99) < gnt_pct)
                                    : ($urandom_range(0, 99) < 10);
            end
        end
    end

    // Monitor: pops the scoreboard on every newly presented instruction and
    // checks hold/drop behaviour and request-address stability each cycle.
    initial begin
        logic        pv, preq;
        logic [31:0] ppc, pinst, paddr, e;
        int          cyc, last_rise;
        pv = 0; preq = 0; ppc = 0; pinst = 0; paddr = 0; e = 0;
        cyc = 0; last_rise = -1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pv = 0; preq = 0; last_rise = -1;
                continue;
            end
            check(ibus_addr[1:0] == 2'b00, "addr_align", ibus_addr, ibus_addr & ~32'h3);
            check(!(ibus_req && if_valid), "req_while_valid", 32'(ibus_req), 32'h0);
            if (pv) begin
                if (stall && !jump_en) begin
                    check(if_valid == 1'b1, "stall_hold_valid", 32'(if_valid), 32'h1);
                    check(if_pc == ppc, "stall_hold_pc", if_pc, ppc);
                    check(if_inst == pinst, "stall_hold_inst", if_inst, pinst);
                    check(ibus_req == 1'b0, "stall_no_req", 32'(ibus_req), 32'h0);
                end else begin
                    check(if_valid == 1'b0, "release_drop", 32'(if_valid), 32'h0);
                    if (jump_en) check(if_inst == NOP, "jump_nop", if_inst, NOP);
                end
            end else if (if_valid) begin
                rises++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "scoreboard_underflow", if_pc, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check(if_pc == e, "inst_pc", if_pc, e);
                    check(if_inst == mem(e), "inst_data", if_inst, mem(e));
                end
                if (chk_period && last_rise >= 0)
                    check(cyc - last_rise == 3, "steady_period", 32'(cyc - last_rise), 32'h3);
                last_rise = cyc;
            end
            if (preq && !ibus_gnt) begin
                check(ibus_req == 1'b1, "req_until_gnt", 32'(ibus_req), 32'h1);
                check(ibus_addr == paddr, "addr_until_gnt", ibus_addr, paddr);
            end
            pv = if_valid; ppc = if_pc; pinst = if_inst;
            preq = ibus_req; paddr = ibus_addr;
        end
    end

    // Stimulus.
    initial begin
        logic [31:0] a;
        rst = 1; stall = 0; jump_en = 0; jump_addr = 0;
        set_target(32'h0);
        repeat (3) @(negedge clk);
        check(if_valid == 1'b0, "rst_if_valid", 32'(if_valid), 32'h0);
        check(if_pc == 32'h0, "rst_if_pc", if_pc, 32'h0);
        check(if_inst == NOP, "rst_if_inst", if_inst, NOP);
        check(ibus_req == 1'b0, "rst_ibus_req", 32'(ibus_req), 32'h0);
        check(ibus_addr == 32'h0, "rst_ibus_addr", ibus_addr, 32'h0);

        // Zero-wait bus, no stall: first fetch at RESET_PC, one instruction per 3 cycles.
        chk_period = 1;
        rst = 0;
        @(posedge clk);
        #1;
        check(ibus_req == 1'b1, "first_req", 32'(ibus_req), 32'h1);
        check(ibus_addr == 32'h0, "first_addr", ibus_addr, 32'h0);
        repeat (20) @(negedge clk);
        chk_period = 0;

        // Hold under stall, then continue sequentially.
        wait_valid("t2_valid");
        stall = 1;
        repeat (5) @(negedge clk);
        stall = 0;

        // Redirect while waiting, response arrives in the same cycle.
        wait_req("t3_req");
        @(negedge clk);
        do_jump(32'h0000_0100);
        wait_valid("t3_valid");

        // Redirect while the request waits for a grant.
        gnt_pct = 0;
        wait_req("t4_req");
        @(negedge clk);
        do_jump(32'h0000_0200);
        gnt_pct = 100;
        wait_valid("t4_valid");

        // PC wrap at the top of the address space.
        wait_req("t5_req");
        do_jump(32'hFFFF_FFFC);
        repeat (12) @(negedge clk);

        // Randomised traffic.
        spur = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            jump_en = 0;
            if (i % 200 == 0) begin
                gnt_pct = $urandom_range(30, 100);
                max_lat = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
                continue;
            end
            stall = ($urandom_range(0, 99) < 30);
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 99) < 5) begin
                case ($urandom_range(0, 7))
                    0:       a = 32'hFFFF_FFFC;
                    1:       a = 32'hFFFF_FFF9;
                    default: a = $urandom();
                endcase
                jump_en   = 1;
                jump_addr = a;
                set_target(a & ~32'h3);
            end
        end
        @(negedge clk);
        jump_en = 0;
        spur = 0;
        check(rises >= 50, "enough_traffic", 32'(rises), 32'd50);

        // Asynchronous reset while holding a stalled instruction.
        stall = 1;
        wait_valid("t6_valid");
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check(if_valid == 1'b0, "t6_async_valid", 32'(if_valid), 32'h0);
        check(if_inst == NOP, "t6_async_inst", if_inst, NOP);
        check(if_pc == 32'h0, "t6_async_pc", if_pc, 32'h0);
        check(ibus_addr == 32'h0, "t6_async_addr", ibus_addr, 32'h0);
        set_target(32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        stall = 0;
        wait_valid("t6_refetch");
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
